// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
package pipe_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   // Occupancy / control-state encodings (number of held beats)
   localparam int unsigned OCC_W     = 2;
   localparam logic [1:0]  OCC_EMPTY = 2'd0;
   localparam logic [1:0]  OCC_ONE   = 2'd1;
   localparam logic [1:0]  OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One {valid, instr, pc} holding register with load, drop and clear.
// Priority: reset > clear > load > drop. Drop invalidates but keeps payload.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int unsigned    DATA_W   = 32,
   parameter int unsigned    PC_W     = 32,
   parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_drop,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [PC_W-1:0]   i_pc,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [PC_W-1:0]   o_pc
);

   logic              r_valid;
   logic [DATA_W-1:0] r_instr;
   logic [PC_W-1:0]   r_pc;

   // Entry register; clear turns the entry into a nop bubble but keeps the PC
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_instr <= DATA_W'(NOP_INSTR);
         r_pc    <= PC_RESET;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_instr <= DATA_W'(NOP_INSTR);
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_drop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush (bubble insertion) and external stall.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned     DATA_W   = 32,
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_DEFAULT),
   parameter int unsigned     SKID     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic [OCC_W-1:0]  occupancy
);

   logic [OCC_W-1:0]  r_occ;
   logic [OCC_W-1:0]  w_occ_nxt;
   logic              r_in_ready;
   logic              w_in_ready_comb;
   logic              w_push;
   logic              w_pop;
   logic              w_main_load;
   logic              w_main_from_skid;
   logic              w_main_drop;
   logic              w_skid_load;
   logic              w_skid_drop;
   logic              w_main_valid;
   logic [DATA_W-1:0] w_main_instr;
   logic [PC_W-1:0]   w_main_pc;
   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_instr;
   logic [PC_W-1:0]   w_skid_pc;
   logic [DATA_W-1:0] w_main_din_instr;
   logic [PC_W-1:0]   w_main_din_pc;
   logic              w_unused;

   // Handshake: single-entry mode exposes a combinational ready
   assign w_in_ready_comb = !w_main_valid || (out_ready && !stall);
   assign in_ready        = (SKID != 0) ? r_in_ready : w_in_ready_comb;
   assign w_push          = in_valid && in_ready;
   assign w_pop           = w_main_valid && out_ready && !stall;

   // Occupancy state register and registered ready (high unless next is FULL)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ      <= OCC_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_occ      <= w_occ_nxt;
         r_in_ready <= (w_occ_nxt != OCC_FULL);
      end
   end

   // Next-state and entry control decode
   always_comb begin
      w_occ_nxt        = r_occ;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_main_drop      = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_drop      = 1'b0;
      if (flush) begin
         w_occ_nxt = OCC_EMPTY;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (w_push) begin
                  w_main_load = 1'b1;
                  w_occ_nxt   = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (w_push && w_pop) begin
                  w_main_load = 1'b1;
               end else if (w_push) begin
                  w_skid_load = 1'b1;
                  w_occ_nxt   = OCC_FULL;
               end else if (w_pop) begin
                  w_main_drop = 1'b1;
                  w_occ_nxt   = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (w_pop) begin
                  w_main_load      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_skid_drop      = 1'b1;
                  w_occ_nxt        = OCC_ONE;
               end
            end
            default: w_occ_nxt = OCC_EMPTY;
         endcase
      end
   end

   assign w_main_din_instr = w_main_from_skid ? w_skid_instr : in_instr;
   assign w_main_din_pc    = w_main_from_skid ? w_skid_pc    : in_pc;

   pipe_entry #(
      .DATA_W   (DATA_W),
      .PC_W     (PC_W),
      .PC_RESET (PC_RESET)
   ) u_main (
      .clk     (clk),
      .reset   (reset),
      .i_clear (flush),
      .i_load  (w_main_load),
      .i_drop  (w_main_drop),
      .i_instr (w_main_din_instr),
      .i_pc    (w_main_din_pc),
      .o_valid (w_main_valid),
      .o_instr (w_main_instr),
      .o_pc    (w_main_pc)
   );

   // Skid entry exists only in two-entry mode
   if (SKID != 0) begin : g_skid
      pipe_entry #(
         .DATA_W   (DATA_W),
         .PC_W     (PC_W),
         .PC_RESET (PC_RESET)
      ) u_skid (
         .clk     (clk),
         .reset   (reset),
         .i_clear (flush),
         .i_load  (w_skid_load),
         .i_drop  (w_skid_drop),
         .i_instr (in_instr),
         .i_pc    (in_pc),
         .o_valid (w_skid_valid),
         .o_instr (w_skid_instr),
         .o_pc    (w_skid_pc)
      );
   end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_instr = '0;
      assign w_skid_pc    = '0;
   end

   // Skid valid mirrors occupancy and the skid strobes are idle without a skid
   assign w_unused = ^{w_skid_valid, w_skid_load, w_skid_drop};

   assign out_valid = w_main_valid;
   assign out_instr = w_main_instr;
   assign out_pc    = w_main_pc;
   assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: both SKID settings driven in lockstep, each checked every
// cycle against a small FIFO model, plus hand-computed literal expectations.
module tb_pipe_stage_reg;

   logic        clk;
   logic        reset, flush, stall, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_instr, s_out_pc;
   logic [1:0]  s_occ;
   logic        n_in_ready, n_out_valid;
   logic [31:0] n_out_instr, n_out_pc;
   logic [1:0]  n_occ;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   pipe_stage_reg #(.DATA_W(32), .PC_W(32), .PC_RESET(32'h0000_3000), .SKID(1)) u_skid (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
      .out_pc(s_out_pc), .occupancy(s_occ)
   );

   pipe_stage_reg #(.DATA_W(32), .PC_W(32), .PC_RESET(32'h0000_3000), .SKID(0)) u_noskid (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
      .out_pc(n_out_pc), .occupancy(n_occ)
   );

   logic        d_rdy [2];
   logic        d_val [2];
   logic [31:0] d_instr [2];
   logic [31:0] d_pc [2];
   logic [1:0]  d_occ [2];
   assign d_rdy[0] = s_in_ready;   assign d_rdy[1] = n_in_ready;
   assign d_val[0] = s_out_valid;  assign d_val[1] = n_out_valid;
   assign d_instr[0] = s_out_instr; assign d_instr[1] = n_out_instr;
   assign d_pc[0] = s_out_pc;      assign d_pc[1] = n_out_pc;
   assign d_occ[0] = s_occ;        assign d_occ[1] = n_occ;

   // Model: per DUT a FIFO of up to 2 beats plus the last visible payload
   logic [31:0] m_instr [2][2];
   logic [31:0] m_pc [2][2];
   int          m_cnt [2];
   logic [31:0] m_last_instr [2];
   logic [31:0] m_last_pc [2];
   logic        m_rdy [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "timeout");
   end

   function automatic string tag(input int m);
      return (m == 0) ? "skid" : "noskid";
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // One cycle: drive, check against model, clock, advance model.
   task automatic step(input logic rst, input logic fl, input logic st, input logic iv,
                       input logic ordy, input logic [31:0] pc, input int exp_nrdy = -1);
      logic e_rdy [2];
      logic push [2];
      logic pop [2];
      @(negedge clk);
      reset = rst; flush = fl; stall = st; in_valid = iv; out_ready = ordy;
      in_pc = pc; in_instr = {16'hC0DE, pc[15:0]};
      #1;
      for (int m = 0; m < 2; m++) begin
         e_rdy[m] = (m == 0) ? m_rdy[0] : ((m_cnt[1] == 0) || (ordy && !st));
         push[m]  = iv && e_rdy[m];
         pop[m]   = (m_cnt[m] > 0) && ordy && !st;
         if (chk_en) begin
            check({tag(m), "_in_ready"}, 32'(d_rdy[m]), 32'(e_rdy[m]));
            check({tag(m), "_out_valid"}, 32'(d_val[m]), 32'(m_cnt[m] > 0));
            check({tag(m), "_out_instr"}, d_instr[m], m_last_instr[m]);
            check({tag(m), "_out_pc"}, d_pc[m], m_last_pc[m]);
            check({tag(m), "_occupancy"}, 32'(d_occ[m]), 32'(m_cnt[m]));
         end
      end
      if (exp_nrdy >= 0) check("noskid_in_ready_same_cycle", 32'(n_in_ready), 32'(exp_nrdy));
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_cnt[m] = 0; m_last_instr[m] = 32'h0; m_last_pc[m] = 32'h0000_3000;
         end else if (fl) begin
            m_cnt[m] = 0; m_last_instr[m] = 32'h0;
         end else begin
            if (pop[m]) begin
               m_instr[m][0] = m_instr[m][1];
               m_pc[m][0]    = m_pc[m][1];
               m_cnt[m]      = m_cnt[m] - 1;
            end
            if (push[m]) begin
               m_instr[m][m_cnt[m]] = {16'hC0DE, pc[15:0]};
               m_pc[m][m_cnt[m]]    = pc;
               m_cnt[m]             = m_cnt[m] + 1;
            end
            if (m_cnt[m] > 0) begin
               m_last_instr[m] = m_instr[m][0];
               m_last_pc[m]    = m_pc[m][0];
            end
         end
         m_rdy[m] = (m_cnt[m] < 2);
      end
      if (rst) chk_en = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      for (int m = 0; m < 2; m++) begin
         m_cnt[m] = 0; m_rdy[m] = 1'b1;
         m_last_instr[m] = 32'h0; m_last_pc[m] = 32'h0000_3000;
      end

      // Reset held two cycles with a beat offered
      step(1, 0, 0, 1, 0, 32'h3000);
      step(1, 0, 0, 1, 0, 32'h3000);
      check("rst_out_valid", 32'(s_out_valid), 32'd0);
      check("rst_out_instr", s_out_instr, 32'h0);
      check("rst_out_pc", s_out_pc, 32'h0000_3000);
      check("rst_in_ready", 32'(s_in_ready), 32'd1);
      check("rst_occupancy", 32'(s_occ), 32'd0);
      check("rst_noskid_pc", n_out_pc, 32'h0000_3000);

      // Streaming, one cycle latency, no gaps
      step(0, 0, 0, 1, 1, 32'h3000);
      check("stream0_pc", s_out_pc, 32'h3000);
      check("stream0_valid", 32'(s_out_valid), 32'd1);
      step(0, 0, 0, 1, 1, 32'h3004);
      check("stream1_pc", s_out_pc, 32'h3004);
      check("stream1_noskid_pc", n_out_pc, 32'h3004);
      step(0, 0, 0, 1, 1, 32'h3008);
      check("stream2_pc", s_out_pc, 32'h3008);
      check("stream2_instr", s_out_instr, 32'hC0DE_3008);
      step(0, 0, 0, 0, 1, 32'h0);
      check("stream_drain_valid", 32'(s_out_valid), 32'd0);
      check("stream_drain_pc_hold", s_out_pc, 32'h3008);
      step(0, 0, 0, 0, 1, 32'h0);

      // Back-pressure fills the skid entry
      step(0, 0, 0, 1, 0, 32'h3000);
      step(0, 0, 0, 1, 0, 32'h3004);
      check("bp_occupancy", 32'(s_occ), 32'd2);
      check("bp_in_ready", 32'(s_in_ready), 32'd0);
      check("bp_head_pc", s_out_pc, 32'h3000);
      check("bp_noskid_occ", 32'(n_occ), 32'd1);
      step(0, 0, 0, 0, 1, 32'h0);
      check("bp_rel_pc", s_out_pc, 32'h3004);
      check("bp_rel_occ", 32'(s_occ), 32'd1);
      check("bp_rel_in_ready", 32'(s_in_ready), 32'd1);
      check("bp_noskid_empty", 32'(n_out_valid), 32'd0);
      step(0, 0, 0, 0, 1, 32'h0);

      // Stall overrides out_ready
      step(0, 0, 0, 1, 0, 32'h3004);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 1, 32'h0);
         check("stall_valid", 32'(s_out_valid), 32'd1);
         check("stall_pc", s_out_pc, 32'h3004);
      end
      step(0, 0, 0, 0, 1, 32'h0);
      check("unstall_popped", 32'(s_out_valid), 32'd0);

      // Flush with a full stage and a beat offered
      step(0, 0, 0, 1, 0, 32'h3010);
      step(0, 0, 0, 1, 0, 32'h3014);
      step(0, 1, 0, 1, 1, 32'h3018);
      check("flush_valid", 32'(s_out_valid), 32'd0);
      check("flush_instr", s_out_instr, 32'h0);
      check("flush_pc_kept", s_out_pc, 32'h3010);
      check("flush_occ", 32'(s_occ), 32'd0);
      check("flush_in_ready", 32'(s_in_ready), 32'd1);
      check("flush_noskid_instr", n_out_instr, 32'h0);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 1, 32'h0);
         check("flush_no_ghost", 32'(s_out_valid), 32'd0);
         check("flush_no_ghost_pc", s_out_pc, 32'h3010);
      end

      // Single-entry mode: combinational ready, push+pop replaces main
      step(0, 0, 0, 1, 0, 32'h3020);
      step(0, 0, 0, 1, 1, 32'h3024, 1);
      check("noskid_replace_pc", n_out_pc, 32'h3024);
      check("noskid_replace_occ", 32'(n_occ), 32'd1);
      step(0, 0, 0, 1, 0, 32'h3028, 0);
      check("noskid_blocked_pc", n_out_pc, 32'h3024);
      check("skid_took_3028", 32'(s_occ), 32'd2);

      // Reset mid-transfer overrides push and pop
      step(1, 0, 0, 1, 1, 32'h3030);
      check("rst_mid_pc", s_out_pc, 32'h0000_3000);
      check("rst_mid_occ", 32'(s_occ), 32'd0);
      check("rst_mid_valid", 32'(s_out_valid), 32'd0);
      check("rst_mid_noskid_instr", n_out_instr, 32'h0);
      step(0, 0, 0, 0, 1, 32'h0);
      step(0, 0, 0, 0, 1, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
